// File: rtl/sprite_motion_ctrl.sv
// Frame-synchronous sprite mover: turns a held USB keycode into a clamped
// top-left sprite position, updated once per rising edge of vsync.
module sprite_motion_ctrl #(
  parameter int X_MAX       = 639,
  parameter int Y_MAX       = 479,
  parameter int SIZE        = 16,
  parameter int STEP        = 4,
  parameter int X_INIT      = 312,
  parameter int Y_INIT      = 232,
  parameter int HOLD_FRAMES = 2
) (
  input  logic       Clk,
  input  logic       Reset,
  input  logic [7:0] keycode,
  input  logic       vsync,
  output logic [9:0] pos_x,
  output logic [9:0] pos_y,
  output logic [1:0] dir,
  output logic       moving,
  output logic       hit
);

  localparam logic [9:0]        X_LIM    = 10'(X_MAX - SIZE + 1);
  localparam logic [9:0]        Y_LIM    = 10'(Y_MAX - SIZE + 1);
  localparam logic signed [10:0] X_LIM_S = 11'(X_MAX - SIZE + 1);
  localparam logic signed [10:0] Y_LIM_S = 11'(Y_MAX - SIZE + 1);
  localparam logic signed [10:0] STEP_S  = 11'(STEP);
  localparam logic [2:0]        HOLD_MAX = 3'(HOLD_FRAMES);

  typedef enum logic {IDLE, MOVE} state_t;
  typedef enum logic [1:0] {DIR_UP, DIR_DOWN, DIR_LEFT, DIR_RIGHT} dir_t;

  state_t     state_q, state_d;
  dir_t       dir_q, dir_d;
  dir_t       cand_dir_q, cand_dir_d;
  logic [2:0] hold_cnt_q, hold_cnt_d;
  logic [9:0] pos_x_q, pos_x_d;
  logic [9:0] pos_y_q, pos_y_d;
  logic       hit_q, hit_d;
  logic       vsync_prev_q, vsync_prev_d;

  logic       tick;
  logic       key_is_dir, key_is_stop;
  dir_t       key_dir;
  logic       accept;
  dir_t       step_dir;
  logic       at_limit;
  logic       step_clamp;
  logic [9:0] step_x, step_y;
  logic signed [10:0] nx, ny;

  assign vsync_prev_d = vsync;
  assign tick         = vsync & ~vsync_prev_q;

  always_comb begin
    // NOTE: every combinational output gets a default first so no path can infer a latch.
    key_is_dir  = 1'b1;
    key_is_stop = 1'b0;
    key_dir     = DIR_UP;
    unique case (keycode)
      8'h1A:   key_dir = DIR_UP;
      8'h16:   key_dir = DIR_DOWN;
      8'h04:   key_dir = DIR_LEFT;
      8'h07:   key_dir = DIR_RIGHT;
      8'h2C:   begin key_is_dir = 1'b0; key_is_stop = 1'b1; end
      default: key_is_dir = 1'b0;
    endcase
  end

  // Hold filter: a direction must be seen on HOLD_FRAMES consecutive ticks.
  always_comb begin
    hold_cnt_d = hold_cnt_q;
    cand_dir_d = cand_dir_q;
    accept     = 1'b0;
    if (tick) begin
      if (key_is_dir) begin
        if (key_dir == cand_dir_q) begin
          hold_cnt_d = (hold_cnt_q >= HOLD_MAX) ? HOLD_MAX : hold_cnt_q + 3'd1;
        end else begin
          cand_dir_d = key_dir;
          hold_cnt_d = 3'd1;
        end
        accept = (hold_cnt_d >= HOLD_MAX);
      end else begin
        hold_cnt_d = 3'd0;
      end
    end
  end

  assign step_dir = accept ? key_dir : dir_q;

  always_comb begin
    at_limit = 1'b0;
    unique case (step_dir)
      DIR_UP:    at_limit = (pos_y_q == 10'd0);
      DIR_DOWN:  at_limit = (pos_y_q == Y_LIM);
      DIR_LEFT:  at_limit = (pos_x_q == 10'd0);
      DIR_RIGHT: at_limit = (pos_x_q == X_LIM);
    endcase
  end

  // Signed 11-bit step so an overshoot past 0 is visible before clamping.
  always_comb begin
    nx         = $signed({1'b0, pos_x_q});
    ny         = $signed({1'b0, pos_y_q});
    step_x     = pos_x_q;
    step_y     = pos_y_q;
    step_clamp = 1'b0;
    unique case (step_dir)
      DIR_UP: begin
        ny = $signed({1'b0, pos_y_q}) - STEP_S;
        if (ny <= 11'sd0) begin step_y = 10'd0; step_clamp = 1'b1; end
        else step_y = 10'(ny);
      end
      DIR_DOWN: begin
        ny = $signed({1'b0, pos_y_q}) + STEP_S;
        if (ny >= Y_LIM_S) begin step_y = Y_LIM; step_clamp = 1'b1; end
        else step_y = 10'(ny);
      end
      DIR_LEFT: begin
        nx = $signed({1'b0, pos_x_q}) - STEP_S;
        if (nx <= 11'sd0) begin step_x = 10'd0; step_clamp = 1'b1; end
        else step_x = 10'(nx);
      end
      DIR_RIGHT: begin
        nx = $signed({1'b0, pos_x_q}) + STEP_S;
        if (nx >= X_LIM_S) begin step_x = X_LIM; step_clamp = 1'b1; end
        else step_x = 10'(nx);
      end
    endcase
  end

  always_comb begin
    logic take_step;
    take_step = 1'b0;
    state_d   = state_q;
    dir_d     = dir_q;
    pos_x_d   = pos_x_q;
    pos_y_d   = pos_y_q;
    hit_d     = 1'b0;
    if (tick) begin
      unique case (state_q)
        IDLE: begin
          if (accept) begin
            dir_d = key_dir;
            if (!at_limit) begin
              state_d   = MOVE;
              take_step = 1'b1;
            end
          end
        end
        MOVE: begin
          if (key_is_stop) begin
            state_d = IDLE;
          end else begin
            if (accept) dir_d = key_dir;
            take_step = 1'b1;
          end
        end
      endcase
    end
    if (take_step) begin
      pos_x_d = step_x;
      pos_y_d = step_y;
      if (step_clamp) begin
        hit_d   = 1'b1;
        state_d = IDLE;
      end
    end
  end

  // NOTE: sequential state uses non-blocking assignments so all flops update together.
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      state_q      <= IDLE;
      dir_q        <= DIR_UP;
      cand_dir_q   <= DIR_UP;
      hold_cnt_q   <= 3'd0;
      pos_x_q      <= 10'(X_INIT);
      pos_y_q      <= 10'(Y_INIT);
      hit_q        <= 1'b0;
      vsync_prev_q <= 1'b1;
    end else begin
      state_q      <= state_d;
      dir_q        <= dir_d;
      cand_dir_q   <= cand_dir_d;
      hold_cnt_q   <= hold_cnt_d;
      pos_x_q      <= pos_x_d;
      pos_y_q      <= pos_y_d;
      hit_q        <= hit_d;
      vsync_prev_q <= vsync_prev_d;
    end
  end

  assign pos_x  = pos_x_q;
  assign pos_y  = pos_y_q;
  assign dir    = dir_q;
  assign moving = (state_q == MOVE);
  assign hit    = hit_q;

endmodule

// File: tb/tb_sprite_motion_ctrl.sv
// Scoreboard bench for sprite_motion_ctrl: a behavioural model predicts the
// packed outputs every cycle; predictions are queued and compared after each edge.
module tb_sprite_motion_ctrl;

  localparam int XB   = 624;
  localparam int YB   = 464;
  localparam int STP  = 4;
  localparam int HOLD = 2;

  logic       Clk = 1'b0;
  logic       Reset;
  logic [7:0] keycode;
  logic       vsync;
  logic [9:0] pos_x, pos_y;
  logic [1:0] dir;
  logic       moving, hit;

  sprite_motion_ctrl dut (
    .Clk(Clk), .Reset(Reset), .keycode(keycode), .vsync(vsync),
    .pos_x(pos_x), .pos_y(pos_y), .dir(dir), .moving(moving), .hit(hit)
  );

  always #5 Clk = ~Clk;

  int n_checks = 0;
  int n_pass   = 0;
  logic [31:0] exp_q[$];

  int         m_x, m_y, m_hold;
  logic [1:0] m_dir, m_cand;
  bit         m_move, m_hit, m_vs_prev;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
  endtask

  function automatic void model_reset();
    m_x = 312; m_y = 232; m_dir = 2'b00; m_move = 0; m_hit = 0;
    m_cand = 2'b00; m_hold = 0; m_vs_prev = 1;
  endfunction

  function automatic void model_step();
    int n;
    case (m_dir)
      2'b00: begin n = m_y - STP; if (n <= 0)  begin m_y = 0;  m_hit = 1; m_move = 0; end else m_y = n; end
      2'b01: begin n = m_y + STP; if (n >= YB) begin m_y = YB; m_hit = 1; m_move = 0; end else m_y = n; end
      2'b10: begin n = m_x - STP; if (n <= 0)  begin m_x = 0;  m_hit = 1; m_move = 0; end else m_x = n; end
      default: begin n = m_x + STP; if (n >= XB) begin m_x = XB; m_hit = 1; m_move = 0; end else m_x = n; end
    endcase
  endfunction

  function automatic void model_tick(input logic [7:0] key);
    logic [1:0] d;
    bit is_dir, is_stop, acc, blocked;
    is_dir = 1; d = 2'b00;
    case (key)
      8'h1A: d = 2'b00;
      8'h16: d = 2'b01;
      8'h04: d = 2'b10;
      8'h07: d = 2'b11;
      default: is_dir = 0;
    endcase
    is_stop = (key == 8'h2C);
    acc = 0;
    if (is_dir) begin
      if (d == m_cand) begin if (m_hold < HOLD) m_hold++; end
      else begin m_cand = d; m_hold = 1; end
      acc = (m_hold >= HOLD);
    end else m_hold = 0;
    m_hit = 0;
    if (!m_move) begin
      if (acc) begin
        m_dir = d;
        blocked = (d == 2'b00 && m_y == 0) || (d == 2'b01 && m_y == YB) ||
                  (d == 2'b10 && m_x == 0) || (d == 2'b11 && m_x == XB);
        if (!blocked) begin m_move = 1; model_step(); end
      end
    end else if (is_stop) begin
      m_move = 0;
    end else begin
      if (acc) m_dir = d;
      model_step();
    end
  endfunction

  function automatic logic [31:0] model_pack();
    return {8'h00, 10'(m_x), 10'(m_y), m_dir, m_move, m_hit};
  endfunction

  task automatic cycle(input logic vs, input logic [7:0] key, input string tag);
    logic [31:0] got;
    @(negedge Clk);
    vsync = vs; keycode = key;
    if (Reset) model_reset();
    else begin
      if (vs && !m_vs_prev) model_tick(key);
      else m_hit = 0;
      m_vs_prev = vs;
    end
    exp_q.push_back(model_pack());
    @(posedge Clk); #1;
    got = {8'h00, pos_x, pos_y, dir, moving, hit};
    if (exp_q.size() == 0) check({tag, "_underflow"}, got, 32'hFFFF_FFFF);
    else check(tag, got, exp_q.pop_front());
  endtask

  // Junk keycodes between ticks must be ignored; the tick lands on the third cycle.
  task automatic frame(input logic [7:0] key, input string tag);
    cycle(1'b0, 8'($urandom_range(0, 255)), tag);
    cycle(1'b0, 8'h07, tag);
    cycle(1'b1, key, tag);
    cycle(1'b1, 8'h04, tag);
  endtask

  initial begin
    Reset = 1'b1; vsync = 1'b1; keycode = 8'h00;
    model_reset();
    repeat (3) cycle(1'b1, 8'h00, "in_reset");
    Reset = 1'b0;
    repeat (10) cycle(1'b1, 8'h00, "vsync_high_release");
    check("init_x", 32'(pos_x), 32'd312);
    check("init_y", 32'(pos_y), 32'd232);

    frame(8'h07, "right_t1");
    check("t1_moving", 32'(moving), 32'd0);
    frame(8'h07, "right_t2");
    check("t2_x", 32'(pos_x), 32'd316);
    check("t2_dir", 32'(dir), 32'd3);
    frame(8'h07, "right_t3");
    check("t3_x", 32'(pos_x), 32'd320);
    frame(8'h2C, "stop_t4");
    frame(8'h2C, "stop_t5");
    check("stop_x", 32'(pos_x), 32'd320);

    repeat (2) frame(8'h07, "right_again");
    repeat (3) frame(8'h00, "momentum");
    repeat (2) frame(8'h1A, "turn_up");
    check("up_dir", 32'(dir), 32'd0);
    repeat (2) frame(8'h00, "up_momentum");
    frame(8'h2C, "stop2");

    for (int i = 0; i < 6; i++) frame((i % 2) ? 8'h16 : 8'h07, "alternate");
    check("alt_moving", 32'(moving), 32'd0);

    Reset = 1'b1; model_reset();
    cycle(1'b1, 8'h00, "reset2");
    Reset = 1'b0;
    repeat (82) frame(8'h04, "left_run");
    check("left_x", 32'(pos_x), 32'd0);

    repeat (62) frame(8'h16, "down_run");
    check("down_y", 32'(pos_y), 32'(YB));

    repeat (4) frame(8'h07, "pre_abort");
    check("pre_abort_moving", 32'(moving), 32'd1);
    #3 Reset = 1'b1;
    #1;
    check("abort_x", 32'(pos_x), 32'd312);
    check("abort_y", 32'(pos_y), 32'd232);
    check("abort_moving", 32'(moving), 32'd0);
    model_reset();
    repeat (2) cycle(1'b0, 8'h07, "abort_held");
    Reset = 1'b0;
    repeat (2) frame(8'h00, "after_abort");
    check("after_abort_x", 32'(pos_x), 32'd312);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
